// File: rtl/light_cmd_parser.sv
// ---------------------------------------------------------------------------
// light_cmd_parser
// Turns the decoded Uart byte stream into pixel-memory writes, a global
// brightness value and a frame-show request for the LED output stage.
//
// Ports
//   clk, rstn        : clock, asynchronous active-low reset
//   dataRecv         : received byte
//   dataRecvCmd      : 1 = byte is a command, 0 = data (qualified by valid)
//   dataRecvValid    : single-cycle byte strobe
//   dataRecvAck      : 1 = bytes are accepted (Uart drops bytes while 0)
//   dataRecvThrottle : 1 = ask the host to pause (Uart cts)
//   memWe/memAddr/memData : pixel-memory write port (one cycle after strobe)
//   brightness       : global brightness register
//   ledBusy          : LED output stage is shifting out a frame
//   frameShow        : single-cycle request to output the current frame
//   frameLen         : bytes written in the last frame, latched at SHOW
//   errCnt           : saturating protocol-error counter
// ---------------------------------------------------------------------------
module light_cmd_parser #(
    parameter int unsigned numBytes  = 900,
    parameter int unsigned addrWidth = 10,
    parameter int unsigned errWidth  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           dataRecv,
    input  logic                 dataRecvCmd,
    input  logic                 dataRecvValid,
    output logic                 dataRecvAck,
    output logic                 dataRecvThrottle,
    output logic                 memWe,
    output logic [addrWidth-1:0] memAddr,
    output logic [7:0]           memData,
    output logic [7:0]           brightness,
    input  logic                 ledBusy,
    output logic                 frameShow,
    output logic [addrWidth-1:0] frameLen,
    output logic [errWidth-1:0]  errCnt
);

    // Write pointer must be able to hold numBytes itself (the "frame full" value).
    localparam int unsigned PTR_W = $clog2(numBytes + 1);

    localparam logic [7:0] CMD_FRAME  = 8'h01;
    localparam logic [7:0] CMD_SHOW   = 8'h02;
    localparam logic [7:0] CMD_BRIGHT = 8'h03;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PIXELS    = 2'd1,
        S_BRIGHT    = 2'd2,
        S_SHOW_WAIT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic               err_inc;
    logic               we_nxt;
    logic               show_nxt;
    logic               len_load;
    logic               bright_load;
    logic               frame_full;

    assign frame_full = (wr_ptr == PTR_W'(numBytes));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-byte actions
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = wr_ptr;
        err_inc     = 1'b0;
        we_nxt      = 1'b0;
        show_nxt    = 1'b0;
        len_load    = 1'b0;
        bright_load = 1'b0;

        if (state == S_SHOW_WAIT) begin
            // Bytes that slip in while throttled are dropped but counted.
            if (dataRecvValid) begin
                err_inc = 1'b1;
            end
            if (!ledBusy) begin
                show_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
        end else if (dataRecvValid && dataRecvCmd) begin
            case (dataRecv)
                CMD_FRAME: begin
                    ptr_nxt   = '0;
                    state_nxt = S_PIXELS;
                end
                CMD_SHOW: begin
                    len_load = 1'b1;
                    if (!ledBusy) begin
                        show_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SHOW_WAIT;
                    end
                end
                CMD_BRIGHT: begin
                    state_nxt = S_BRIGHT;
                end
                default: begin
                    err_inc = 1'b1;
                end
            endcase
        end else if (dataRecvValid) begin
            case (state)
                S_PIXELS: begin
                    if (frame_full) begin
                        err_inc = 1'b1;
                    end else begin
                        we_nxt  = 1'b1;
                        ptr_nxt = wr_ptr + PTR_W'(1);
                    end
                end
                S_BRIGHT: begin
                    bright_load = 1'b1;
                    state_nxt   = S_IDLE;
                end
                default: begin
                    err_inc = 1'b1;
                end
            endcase
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr           <= '0;
            memWe            <= 1'b0;
            memAddr          <= '0;
            memData          <= '0;
            brightness       <= 8'hff;
            frameShow        <= 1'b0;
            frameLen         <= '0;
            errCnt           <= '0;
            dataRecvAck      <= 1'b1;
            dataRecvThrottle <= 1'b0;
        end else begin
            wr_ptr    <= ptr_nxt;
            memWe     <= we_nxt;
            frameShow <= show_nxt;
            if (we_nxt) begin
                memAddr <= addrWidth'(wr_ptr);
                memData <= dataRecv;
            end
            if (len_load) begin
                frameLen <= addrWidth'(wr_ptr);
            end
            if (bright_load) begin
                brightness <= dataRecv;
            end
            if (err_inc && (errCnt != '1)) begin
                errCnt <= errCnt + errWidth'(1);
            end
            // Flow control follows the state being entered so it changes with it.
            dataRecvAck      <= (state_nxt != S_SHOW_WAIT);
            dataRecvThrottle <= (state_nxt == S_SHOW_WAIT);
        end
    end

endmodule

// File: tb/tb_light_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_light_cmd_parser
// Randomized stimulus with a transaction-level reference model; expected
// memory writes and frame-show events are queued at stimulus time and popped
// by an independent monitor that samples the DUT on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_light_cmd_parser;

    localparam int unsigned NUM_BYTES = 900;
    localparam int unsigned AW        = 10;
    localparam int unsigned EW        = 8;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [7:0]     dataRecv = 8'h00;
    logic           dataRecvCmd = 1'b0;
    logic           dataRecvValid = 1'b0;
    logic           ledBusy = 1'b0;
    logic           dataRecvAck;
    logic           dataRecvThrottle;
    logic           memWe;
    logic [AW-1:0]  memAddr;
    logic [7:0]     memData;
    logic [7:0]     brightness;
    logic           frameShow;
    logic [AW-1:0]  frameLen;
    logic [EW-1:0]  errCnt;

    light_cmd_parser #(
        .numBytes (NUM_BYTES),
        .addrWidth(AW),
        .errWidth (EW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .dataRecv        (dataRecv),
        .dataRecvCmd     (dataRecvCmd),
        .dataRecvValid   (dataRecvValid),
        .dataRecvAck     (dataRecvAck),
        .dataRecvThrottle(dataRecvThrottle),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memData         (memData),
        .brightness      (brightness),
        .ledBusy         (ledBusy),
        .frameShow       (frameShow),
        .frameLen        (frameLen),
        .errCnt          (errCnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_PIX, M_BRI, M_WAIT} mode_t;
    typedef struct { int unsigned due; logic [AW-1:0] addr; logic [7:0] data; } wr_exp_t;
    typedef struct { int unsigned due; logic [AW-1:0] len; } show_exp_t;

    wr_exp_t     exp_wr[$];
    show_exp_t   exp_show[$];
    mode_t       m_mode   = M_IDLE;
    int unsigned m_ptr    = 0;
    int unsigned m_len    = 0;
    int unsigned m_err    = 0;
    logic [7:0]  m_bright = 8'hff;

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_ptr    = 0;
        m_len    = 0;
        m_err    = 0;
        m_bright = 8'hff;
        exp_wr.delete();
        exp_show.delete();
    endtask

    // One sampled cycle of the protocol, seen as a byte-level transaction.
    task automatic model_apply(input bit v, input bit c, input logic [7:0] b,
                               input bit busy, input int unsigned due);
        if (m_mode == M_WAIT) begin
            if (v) bump_err();
            if (!busy) begin
                exp_show.push_back('{due, AW'(m_len)});
                m_mode = M_IDLE;
            end
        end else if (v && c) begin
            if (b == 8'h01) begin
                m_ptr  = 0;
                m_mode = M_PIX;
            end else if (b == 8'h02) begin
                m_len = m_ptr;
                if (busy) m_mode = M_WAIT;
                else begin
                    exp_show.push_back('{due, AW'(m_len)});
                    m_mode = M_IDLE;
                end
            end else if (b == 8'h03) begin
                m_mode = M_BRI;
            end else begin
                bump_err();
            end
        end else if (v) begin
            if (m_mode == M_PIX && m_ptr < NUM_BYTES) begin
                exp_wr.push_back('{due, AW'(m_ptr), b});
                m_ptr++;
            end else if (m_mode == M_BRI) begin
                m_bright = b;
                m_mode   = M_IDLE;
            end else begin
                bump_err();
            end
        end
    endtask

    // ---------------- monitor ----------------
    wr_exp_t   mon_w;
    show_exp_t mon_s;

    always @(negedge clk) begin
        if (rstn) begin
            while (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
                check("we_missing", cyc, exp_wr[0].due);
                void'(exp_wr.pop_front());
            end
            while (exp_show.size() > 0 && exp_show[0].due < cyc) begin
                check("show_missing", cyc, exp_show[0].due);
                void'(exp_show.pop_front());
            end
            if (memWe) begin
                check("we_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    mon_w = exp_wr.pop_front();
                    check("we_cycle", cyc, mon_w.due);
                    check("we_addr", 32'(memAddr), 32'(mon_w.addr));
                    check("we_data", 32'(memData), 32'(mon_w.data));
                end
            end
            if (frameShow) begin
                check("show_expected", 32'(exp_show.size() > 0), 32'd1);
                if (exp_show.size() > 0) begin
                    mon_s = exp_show.pop_front();
                    check("show_cycle", cyc, mon_s.due);
                    check("frame_len", 32'(frameLen), 32'(mon_s.len));
                end
            end
            check("ack", 32'(dataRecvAck), 32'(m_mode != M_WAIT));
            check("throttle", 32'(dataRecvThrottle), 32'(m_mode == M_WAIT));
            check("brightness", 32'(brightness), 32'(m_bright));
            check("err_cnt", 32'(errCnt), m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit v, input bit c, input logic [7:0] b);
        int unsigned due;
        bit          busy;
        dataRecvValid = v;
        dataRecvCmd   = c;
        dataRecv      = b;
        due           = cyc + 1;
        busy          = ledBusy;
        @(posedge clk);
        #1;
        model_apply(v, c, b, busy, due);
        dataRecvValid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic data_byte(input logic [7:0] b);
        idle($urandom_range(0, 1));
        step(1'b1, 1'b0, b);
    endtask

    task automatic do_show(input int unsigned busy_cycles);
        ledBusy = (busy_cycles != 0);
        step(1'b1, 1'b1, 8'h02);
        for (int i = 1; i < int'(busy_cycles); i++)
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
        ledBusy = 1'b0;
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_memWe", 32'(memWe), 32'd0);
        check("rst_memAddr", 32'(memAddr), 32'd0);
        check("rst_memData", 32'(memData), 32'd0);
        check("rst_brightness", 32'(brightness), 32'hff);
        check("rst_frameShow", 32'(frameShow), 32'd0);
        check("rst_frameLen", 32'(frameLen), 32'd0);
        check("rst_errCnt", 32'(errCnt), 32'd0);
        check("rst_ack", 32'(dataRecvAck), 32'd1);
        check("rst_throttle", 32'(dataRecvThrottle), 32'd0);
        model_reset();
        dataRecvValid = 1'b0;
        ledBusy       = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        do_reset();

        // Basic frame of three pixels, shown with the LED stage idle.
        idle(2);
        step(1'b1, 1'b1, 8'h01);
        data_byte(8'h11);
        data_byte(8'h22);
        data_byte(8'h33);
        do_show(0);

        // Brightness, then a stray data byte in idle.
        step(1'b1, 1'b1, 8'h03);
        step(1'b1, 1'b0, 8'h40);
        idle(1);
        step(1'b1, 1'b0, 8'h5a);

        // Overfull frame: 902 random bytes, only 900 may be written.
        step(1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 902; i++) data_byte(8'($urandom));
        do_show($urandom_range(0, 1) == 1 ? 5 : 0);

        // Show while busy for 50 cycles; release coincides with a dropped byte.
        step(1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 7; i++) data_byte(8'($urandom));
        ledBusy = 1'b1;
        step(1'b1, 1'b1, 8'h02);
        for (int i = 0; i < 49; i++)
            step($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
        ledBusy = 1'b0;
        step(1'b1, 1'b0, 8'haa);
        idle(2);

        // Empty frame is a legal show.
        step(1'b1, 1'b1, 8'h01);
        do_show(0);

        // Random command/data mix with random LED busy.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [7:0]  b;
            bit          c;
            ledBusy = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            c = (r < 4);
            case (r)
                0: b = 8'h01;
                1: b = 8'h02;
                2: b = 8'h03;
                3: b = 8'($urandom_range(4, 255));
                default: b = 8'($urandom);
            endcase
            step($urandom_range(0, 3) != 0, c, b);
        end
        ledBusy = 1'b0;
        idle(3);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 8'h7f);
        idle(1);
        check("err_saturated", 32'(errCnt), 32'hff);

        // Reset in the middle of a frame discards it.
        step(1'b1, 1'b1, 8'h01);
        for (int i = 0; i < 5; i++) data_byte(8'($urandom));
        do_reset();
        step(1'b1, 1'b0, 8'h77);
        idle(4);
        check("post_reset_err", 32'(errCnt), 32'd1);

        idle(4);
        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("show_queue_drained", exp_show.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
